// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// D has fixed priority; a starvation counter forces an I win.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          iReq,
  input  logic [AW-1:0] iAddr,
  output logic          iGnt,
  output logic          iRvalid,
  output logic [31:0]   iRdata,
  input  logic          dReq,
  input  logic          dWe,
  input  logic [AW-1:0] dAddr,
  input  logic [31:0]   dWdata,
  input  logic [3:0]    dBe,
  output logic          dGnt,
  output logic          dRvalid,
  output logic [31:0]   dRdata,
  output logic          memReq,
  output logic          memWe,
  output logic [AW-1:0] memAddr,
  output logic [31:0]   memWdata,
  output logic [3:0]    memBe,
  input  logic          memGnt,
  input  logic          memRvalid,
  input  logic [31:0]   memRdata,
  output logic          busy,
  output logic          protoErr
);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  state_t     r_state;
  logic       r_own_d;
  logic [3:0] r_cnt;
  logic       r_perr;

  logic w_idle;
  logic w_req;
  logic w_force_i;
  logic w_win_i;
  logic w_acc;
  logic w_rsp;
  logic w_perr;

  assign w_idle    = (r_state == S_IDLE);
  assign w_req     = w_idle & (iReq | dReq);
  assign w_force_i = iReq & (r_cnt == LIM);
  assign w_win_i   = w_force_i | ~dReq;
  assign w_acc     = w_req & memGnt;
  assign w_rsp     = ~w_idle & memRvalid;
  // Stray response in IDLE or a grant nobody asked for.
  assign w_perr    = (w_idle & memRvalid)
                   | (memGnt & ~w_req);

  assign memReq   = w_req;
  assign memWe    = w_req & ~w_win_i & dWe;
  assign memAddr  = !w_req  ? '0
                  : w_win_i ? iAddr : dAddr;
  assign memWdata = (!w_req || w_win_i) ? '0 : dWdata;
  assign memBe    = !w_req  ? 4'h0
                  : w_win_i ? 4'hF : dBe;

  assign iGnt    = w_acc & w_win_i;
  assign dGnt    = w_acc & ~w_win_i;
  assign iRvalid = w_rsp & ~r_own_d;
  assign dRvalid = w_rsp & r_own_d;
  assign iRdata  = memRdata;
  assign dRdata  = memRdata;

  assign busy     = ~w_idle;
  assign protoErr = r_perr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_own_d <= 1'b0;
      r_cnt   <= 4'd0;
      r_perr  <= 1'b0;
    end else begin
      if (w_perr) r_perr <= 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_state <= S_WAIT;
            r_own_d <= ~w_win_i;
            if (w_win_i)
              r_cnt <= 4'd0;
            else if (!iReq)
              r_cnt <= 4'd0;
            else if (r_cnt != LIM)
              r_cnt <= r_cnt + 4'd1;
          end
        end
        S_WAIT: begin
          if (memRvalid) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter.
// Grants push expected responses; rvalids pop and compare.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iReq;
  logic [31:0] iAddr;
  logic        iGnt, iRvalid;
  logic [31:0] iRdata;
  logic        dReq, dWe;
  logic [31:0] dAddr, dWdata;
  logic [3:0]  dBe;
  logic        dGnt, dRvalid;
  logic [31:0] dRdata;
  logic        memReq, memWe;
  logic [31:0] memAddr, memWdata;
  logic [3:0]  memBe;
  logic        memGnt;
  logic        memRvalid;
  logic [31:0] memRdata;
  logic        busy, protoErr;

  bit gnt_en;
  bit gnt_force;
  int lat;
  bit pend;
  int pcnt;
  logic [31:0] prd;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    bit          d;
    logic [31:0] data;
    bit          chk;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  assign memGnt = gnt_force | (gnt_en & memReq);

  mem_port_arbiter #(.STARVE_LIMIT(4), .AW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .iReq(iReq), .iAddr(iAddr), .iGnt(iGnt),
    .iRvalid(iRvalid), .iRdata(iRdata),
    .dReq(dReq), .dWe(dWe), .dAddr(dAddr),
    .dWdata(dWdata), .dBe(dBe), .dGnt(dGnt),
    .dRvalid(dRvalid), .dRdata(dRdata),
    .memReq(memReq), .memWe(memWe),
    .memAddr(memAddr), .memWdata(memWdata),
    .memBe(memBe), .memGnt(memGnt),
    .memRvalid(memRvalid), .memRdata(memRdata),
    .busy(busy), .protoErr(protoErr)
  );

  function automatic logic [31:0] mem_data(
    input logic [31:0] a);
    if (a == 32'h100) return 32'h0050_0093;
    return a ^ 32'hA5A5_0000;
  endfunction

  // One clock: capture accept, advance memory, score rvalid.
  task automatic step();
    bit   acc;
    exp_t e;
    #1;
    acc = memReq && memGnt;
    if (acc) begin
      pend = 1;
      pcnt = lat - 1;
      prd  = mem_data(memAddr);
      if (iGnt)
        q.push_back('{d: 1'b0,
          data: mem_data(iAddr), chk: 1'b1});
      if (dGnt)
        q.push_back('{d: 1'b1,
          data: mem_data(dAddr), chk: !dWe});
    end
    @(negedge clk);
    memRvalid = 1'b0;
    memRdata  = '0;
    if (pend) begin
      if (pcnt == 0) begin
        memRvalid = 1'b1;
        memRdata  = prd;
        pend      = 0;
      end else begin
        pcnt--;
      end
    end
    #1;
    if (iRvalid || dRvalid ||
        (memRvalid && q.size() != 0)) begin
      checks++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected got i=%b d=%b exp none",
          iRvalid, dRvalid);
      end else begin
        e = q.pop_front();
        if ({dRvalid, iRvalid} !== {e.d, !e.d} ||
            (e.chk && iRvalid && iRdata !== e.data) ||
            (e.chk && dRvalid && dRdata !== e.data)) begin
          fails++;
          $display("FAIL sb_rsp got i=%b d=%b id=%h dd=%h exp d=%b data=%h",
            iRvalid, dRvalid, iRdata, dRdata, e.d, e.data);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 0; iReq = 0; dReq = 0; dWe = 0;
    iAddr = '0; dAddr = '0; dWdata = '0; dBe = '0;
    memRvalid = 0; memRdata = '0;
    gnt_en = 0; gnt_force = 0; lat = 1; pend = 0;
    @(negedge clk);
    #1;
    checks++;
    if ({memReq, iGnt, dGnt, iRvalid, dRvalid,
         busy, protoErr} !== 7'd0) begin
      fails++;
      $display("FAIL reset_ctl got=%b exp=0",
        {memReq, iGnt, dGnt, iRvalid, dRvalid, busy, protoErr});
    end
    checks++;
    if ({memWe, memAddr, memWdata, memBe} !== '0) begin
      fails++;
      $display("FAIL reset_fields got a=%h w=%h be=%h exp 0",
        memAddr, memWdata, memBe);
    end
    rst_n = 1;
    step();
  endtask

  task automatic test_single_fetch();
    int nb = 0;
    lat = 2; gnt_en = 1;
    iReq = 1; iAddr = 32'h100;
    #1;
    checks++;
    if ({iGnt, dGnt, memWe} !== 3'b100) begin
      fails++;
      $display("FAIL fetch_gnt got=%b exp=100",
        {iGnt, dGnt, memWe});
    end
    checks++;
    if (memAddr !== 32'h100 || memBe !== 4'hF ||
        memWdata !== 32'h0) begin
      fails++;
      $display("FAIL fetch_fields got a=%h be=%h exp a=100 be=f",
        memAddr, memBe);
    end
    step();
    iReq = 0;
    for (int c = 0; c < 5; c++) begin
      if (busy) nb++;
      step();
    end
    checks++;
    if (nb != 2 || q.size() != 0) begin
      fails++;
      $display("FAIL fetch_busy got=%0d q=%0d exp=2 q=0",
        nb, q.size());
    end
  endtask

  task automatic test_simultaneous();
    lat = 1;
    iReq = 1; iAddr = 32'h104;
    dReq = 1; dWe = 0; dAddr = 32'h2000;
    #1;
    checks++;
    if ({dGnt, iGnt} !== 2'b10 || memAddr !== 32'h2000) begin
      fails++;
      $display("FAIL simul_d got g=%b a=%h exp g=10 a=2000",
        {dGnt, iGnt}, memAddr);
    end
    step();
    dReq = 0;
    #1;
    checks++;
    if ({memReq, iGnt} !== 2'b00) begin
      fails++;
      $display("FAIL simul_bubble got=%b exp=00",
        {memReq, iGnt});
    end
    step();
    #1;
    checks++;
    if (iGnt !== 1'b1 || memAddr !== 32'h104) begin
      fails++;
      $display("FAIL simul_i got g=%b a=%h exp g=1 a=104",
        iGnt, memAddr);
    end
    step();
    iReq = 0;
    step();
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL simul_drain got=%0d exp=0", q.size());
    end
  endtask

  task automatic test_starvation();
    bit exp_d;
    lat = 1;
    iReq = 1; iAddr = 32'h180;
    dReq = 1; dWe = 0; dAddr = 32'h2200;
    for (int k = 0; k < 6; k++) begin
      #1;
      exp_d = (k != 4);
      checks++;
      if (dGnt !== exp_d || iGnt !== !exp_d) begin
        fails++;
        $display("FAIL starve_%0d got d=%b i=%b exp d=%b i=%b",
          k, dGnt, iGnt, exp_d, !exp_d);
      end
      step();
      step();
    end
    iReq = 0; dReq = 0;
    step();
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL starve_drain got=%0d exp=0", q.size());
    end
  endtask

  task automatic test_store();
    lat = 1;
    dReq = 1; dWe = 1; dAddr = 32'h3004;
    dWdata = 32'hDEAD_BEEF; dBe = 4'b0011;
    #1;
    checks++;
    if ({memWe, dGnt, iGnt} !== 3'b110 ||
        memAddr !== 32'h3004 ||
        memWdata !== 32'hDEAD_BEEF ||
        memBe !== 4'b0011) begin
      fails++;
      $display("FAIL store_fields got we=%b a=%h w=%h be=%h exp we=1 a=3004 w=deadbeef be=3",
        memWe, memAddr, memWdata, memBe);
    end
    step();
    dReq = 0; dWe = 0;
    step();
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL store_ack got q=%0d exp=0", q.size());
    end
  endtask

  task automatic test_backpressure();
    bit exp_d;
    lat = 1; gnt_en = 0;
    iReq = 1; iAddr = 32'h240;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        dReq = 1; dWe = 0; dAddr = 32'h2300;
      end
      #1;
      exp_d = (c >= 1);
      checks++;
      if ({iGnt, dGnt, busy} !== 3'b000 ||
          memReq !== 1'b1 ||
          memAddr !== (exp_d ? 32'h2300 : 32'h240)) begin
        fails++;
        $display("FAIL bp_hold_%0d got g=%b a=%h exp g=000 a=%h",
          c, {iGnt, dGnt, busy}, memAddr,
          exp_d ? 32'h2300 : 32'h240);
      end
      step();
    end
    gnt_en = 1;
    #1;
    checks++;
    if ({dGnt, iGnt} !== 2'b10) begin
      fails++;
      $display("FAIL bp_grant got=%b exp=10", {dGnt, iGnt});
    end
    step();
    dReq = 0;
    step();
    #1;
    checks++;
    if (iGnt !== 1'b1) begin
      fails++;
      $display("FAIL bp_i_after got=%b exp=1", iGnt);
    end
    step();
    iReq = 0;
    step();
    step();
    checks++;
    if (q.size() != 0 || protoErr !== 1'b0) begin
      fails++;
      $display("FAIL bp_drain got q=%0d pe=%b exp q=0 pe=0",
        q.size(), protoErr);
    end
  endtask

  task automatic test_proto_idle_rvalid();
    memRvalid = 1; memRdata = 32'h1234;
    #1;
    checks++;
    if ({iRvalid, dRvalid} !== 2'b00) begin
      fails++;
      $display("FAIL proto_rv got=%b exp=00",
        {iRvalid, dRvalid});
    end
    step();
    checks++;
    if (protoErr !== 1'b1) begin
      fails++;
      $display("FAIL proto_set got=%b exp=1", protoErr);
    end
    repeat (3) step();
    checks++;
    if (protoErr !== 1'b1) begin
      fails++;
      $display("FAIL proto_sticky got=%b exp=1", protoErr);
    end
  endtask

  task automatic test_reset_wait();
    bit saw_rv = 0;
    lat = 3; gnt_en = 1;
    iReq = 1; iAddr = 32'h300;
    step();
    iReq = 0;
    step();
    #1;
    checks++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL rstw_busy got=%b exp=1", busy);
    end
    rst_n = 0;
    #1;
    checks++;
    if ({memReq, iGnt, dGnt, iRvalid, dRvalid,
         busy, protoErr} !== 7'd0) begin
      fails++;
      $display("FAIL rstw_async got=%b exp=0",
        {memReq, iGnt, dGnt, iRvalid, dRvalid, busy, protoErr});
    end
    pend = 0;
    q.delete();
    step();
    rst_n = 1;
    for (int c = 0; c < 4; c++) begin
      step();
      if (iRvalid || dRvalid || busy) saw_rv = 1;
    end
    checks++;
    if (saw_rv) begin
      fails++;
      $display("FAIL rstw_after got=1 exp=0");
    end
  endtask

  task automatic test_gnt_noreq();
    gnt_force = 1;
    step();
    gnt_force = 0;
    #1;
    checks++;
    if (protoErr !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL gnt_noreq got pe=%b busy=%b exp pe=1 busy=0",
        protoErr, busy);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_store();
    test_backpressure();
    test_proto_idle_rvalid();
    test_reset_wait();
    test_gnt_noreq();
    $display("TB_RESULT checks=%0d failures=%0d",
      checks, fails);
    $finish;
  end

endmodule
